alu_kontrol: RTL and testbench

ALU_KONTROL -- requirements
Module: alu_kontrol

---
 rtl/alu_kontrol.sv | 107 ++++++++++
 tb/tb_alu_kontrol.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_kontrol.sv
// alu_kontrol: command sequencer driving an external ALU, holding accumulator, flags and STORE output
module alu_kontrol #(
  parameter int DIV0_KORU = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kod,
  input  logic [3:0] cmd_secme,
  input  logic [7:0] cmd_sayi,
  output logic [7:0] AC,
  output logic [7:0] Sayi,
  output logic [3:0] Secme,
  input  logic [7:0] ALU_Out,
  input  logic       CarryOut,
  output logic [7:0] sonuc,
  output logic       sonuc_valid,
  input  logic       sonuc_ready,
  output logic       bayrak_C,
  output logic       bayrak_Z,
  output logic       hata_div0
);
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
  localparam logic [1:0] K_ALU = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10;
  state_t state, state_n;
  logic [1:0] kod, kod_n;
  logic [7:0] ac_n, sayi_n, sonuc_n;
  logic [3:0] secme_n;
  logic sv_n, c_n, z_n, h_n, div0;
  assign cmd_ready = state == IDLE;
  assign div0 = DIV0_KORU != 0 && Secme == 4'b0011 && Sayi == 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      kod <= K_ALU;
      AC <= '0;
      Sayi <= '0;
      Secme <= '0;
      sonuc <= '0;
      sonuc_valid <= 1'b0;
      bayrak_C <= 1'b0;
      bayrak_Z <= 1'b0;
      hata_div0 <= 1'b0;
    end else begin
      state <= state_n;
      kod <= kod_n;
      AC <= ac_n;
      Sayi <= sayi_n;
      Secme <= secme_n;
      sonuc <= sonuc_n;
      sonuc_valid <= sv_n;
      bayrak_C <= c_n;
      bayrak_Z <= z_n;
      hata_div0 <= h_n;
    end
  always_comb begin
    state_n = state;
    kod_n = kod;
    ac_n = AC;
    sayi_n = Sayi;
    secme_n = Secme;
    sonuc_n = sonuc;
    sv_n = sonuc_valid;
    c_n = bayrak_C;
    z_n = bayrak_Z;
    h_n = hata_div0;
    case (state)
      IDLE: if (cmd_valid) begin
        state_n = EXEC;
        kod_n = cmd_kod;
        sayi_n = cmd_sayi;
        secme_n = cmd_kod == K_ALU ? cmd_secme : Secme;
      end
      EXEC: begin
        state_n = kod == K_STORE ? OUT : IDLE;
        case (kod)
          K_ALU: if (div0) h_n = 1'b1;
          else begin
            ac_n = ALU_Out;
            z_n = ALU_Out == 8'h00;
            c_n = Secme == 4'b0000 ? CarryOut : bayrak_C;
          end
          K_LOAD: begin
            ac_n = Sayi;
            z_n = Sayi == 8'h00;
          end
          K_STORE: begin
            sonuc_n = AC;
            sv_n = 1'b1;
          end
          default: begin
            ac_n = 8'h00;
            c_n = 1'b0;
            z_n = 1'b1;
            h_n = 1'b0;
          end
        endcase
      end
      OUT: if (sonuc_ready) begin
        sv_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_kontrol.sv
// tb_alu_kontrol: directed checks of alu_kontrol against a small behavioural ALU
module tb_alu_kontrol;
  logic clk, rst_n, cmd_valid, cmd_ready, CarryOut, sonuc_valid, sonuc_ready;
  logic bayrak_C, bayrak_Z, hata_div0;
  logic [1:0] cmd_kod;
  logic [3:0] cmd_secme, Secme;
  logic [7:0] cmd_sayi, AC, Sayi, ALU_Out, sonuc;
  int passed = 0, failed = 0, total = 0, acc;
  logic [5:0] pat;
  localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, STORE = 2'b10, CLEAR = 2'b11;

  alu_kontrol #(.DIV0_KORU(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kod(cmd_kod), .cmd_secme(cmd_secme), .cmd_sayi(cmd_sayi),
    .AC(AC), .Sayi(Sayi), .Secme(Secme), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
    .sonuc(sonuc), .sonuc_valid(sonuc_valid), .sonuc_ready(sonuc_ready),
    .bayrak_C(bayrak_C), .bayrak_Z(bayrak_Z), .hata_div0(hata_div0)
  );

  // external ALU: 0000 add, 0001 sub, 0011 div, 1111 equality, others AND
  always_comb begin
    CarryOut = 1'b0;
    ALU_Out = AC & Sayi;
    if (Secme == 4'b0000) {CarryOut, ALU_Out} = {1'b0, AC} + {1'b0, Sayi};
    else if (Secme == 4'b0001) ALU_Out = AC - Sayi;
    else if (Secme == 4'b0011) ALU_Out = Sayi == 8'h00 ? 8'hFF : AC / Sayi;
    else if (Secme == 4'b1111) ALU_Out = {7'b0, AC == Sayi};
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] k, input logic [3:0] s, input logic [7:0] d);
    cmd_kod = k;
    cmd_secme = s;
    cmd_sayi = d;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("busy_exec", {7'b0, cmd_ready}, 8'h00);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    cmd_valid = 1;
    cmd_kod = LOAD;
    cmd_secme = 0;
    cmd_sayi = 8'hAA;
    sonuc_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_AC", AC, 8'h00);
    chk("rst_Sayi", Sayi, 8'h00);
    chk("rst_Secme", {4'b0, Secme}, 8'h00);
    chk("rst_sonuc", sonuc, 8'h00);
    chk("rst_flags", {4'b0, sonuc_valid, bayrak_C, bayrak_Z, hata_div0}, 8'h00);
    cmd_valid = 0;
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", {7'b0, cmd_ready}, 8'h01);

    cmd(LOAD, 4'h0, 8'hF0);
    chk("load_AC", AC, 8'hF0);
    chk("load_ready", {7'b0, cmd_ready}, 8'h01);
    cmd(ALU, 4'h0, 8'h20);
    chk("add_AC", AC, 8'h10);
    chk("add_CZ", {6'b0, bayrak_C, bayrak_Z}, 8'h02);
    chk("add_ready", {7'b0, cmd_ready}, 8'h01);

    cmd(LOAD, 4'h0, 8'h05);
    cmd(ALU, 4'h3, 8'h00);
    chk("div0_AC", AC, 8'h05);
    chk("div0_err", {5'b0, bayrak_C, bayrak_Z, hata_div0}, 8'h05);
    cmd(CLEAR, 4'h0, 8'h00);
    chk("clr_AC", AC, 8'h00);
    chk("clr_flags", {5'b0, bayrak_C, bayrak_Z, hata_div0}, 8'h02);
    chk("clr_secme_hold", {4'b0, Secme}, 8'h03);

    cmd(LOAD, 4'h0, 8'hF0);
    cmd(ALU, 4'h0, 8'h20);
    cmd(LOAD, 4'h0, 8'h7A);
    chk("load_keepC", {6'b0, bayrak_C, bayrak_Z}, 8'h02);
    cmd(ALU, 4'hF, 8'h7A);
    chk("eq_AC", AC, 8'h01);
    chk("eq_CZ", {6'b0, bayrak_C, bayrak_Z}, 8'h02);
    cmd(ALU, 4'h1, 8'h01);
    chk("sub_AC", AC, 8'h00);
    chk("sub_CZ", {6'b0, bayrak_C, bayrak_Z}, 8'h03);
    cmd(LOAD, 4'h0, 8'h00);
    chk("load0_Z", {7'b0, bayrak_Z}, 8'h01);

    cmd(LOAD, 4'h0, 8'h3C);
    cmd(STORE, 4'h0, 8'h00);
    cmd_kod = LOAD;
    cmd_sayi = 8'h55;
    cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("out_sonuc", sonuc, 8'h3C);
      chk("out_valid", {7'b0, sonuc_valid}, 8'h01);
      chk("out_ready", {7'b0, cmd_ready}, 8'h00);
      @(negedge clk);
    end
    sonuc_ready = 1;
    cmd_valid = 0;
    @(negedge clk);
    sonuc_ready = 0;
    chk("hs_valid", {7'b0, sonuc_valid}, 8'h00);
    chk("hs_ready", {7'b0, cmd_ready}, 8'h01);
    chk("hs_sonuc_hold", sonuc, 8'h3C);
    chk("hs_AC", AC, 8'h3C);
    chk("hs_Sayi", Sayi, 8'h00);

    acc = 0;
    cmd_kod = LOAD;
    cmd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      cmd_sayi = 8'(i + 1);
      pat[i] = cmd_ready;
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 0;
    chk("b2b_count", 8'(acc), 8'd3);
    chk("b2b_pattern", {2'b0, pat}, 8'h15);
    chk("b2b_AC", AC, 8'h05);

    cmd(LOAD, 4'h0, 8'h99);
    cmd(STORE, 4'h0, 8'h00);
    chk("st2_valid", {7'b0, sonuc_valid}, 8'h01);
    chk("st2_sonuc", sonuc, 8'h99);
    rst_n = 0;
    #1;
    chk("rout_valid", {7'b0, sonuc_valid}, 8'h00);
    chk("rout_AC", AC, 8'h00);
    chk("rout_sonuc", sonuc, 8'h00);
    chk("rout_regs", Sayi | {4'b0, Secme} | {5'b0, bayrak_C, bayrak_Z, hata_div0}, 8'h00);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rout_ready", {7'b0, cmd_ready}, 8'h01);

    cmd(LOAD, 4'h0, 8'h42);
    cmd_kod = ALU;
    cmd_secme = 4'h0;
    cmd_sayi = 8'h01;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    rst_n = 0;
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rexec_AC", AC, 8'h00);
    chk("rexec_ready", {7'b0, cmd_ready}, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
